// File: rtl/mem_store_buffer.sv
// Store buffer between MEM and data memory: queues retired stores, drains them in order,
// and forwards buffered bytes to loads (stalling on partial coverage).
module mem_store_buffer #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 4,
    parameter bit          COALESCE = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_st_valid,
    input  logic [ADDR_W-1:0]        i_st_addr,
    input  logic [DATA_W-1:0]        i_st_data,
    input  logic [DATA_W/8-1:0]      i_st_be,
    output logic                     o_st_ready,
    input  logic                     i_ld_valid,
    input  logic [ADDR_W-1:0]        i_ld_addr,
    input  logic [DATA_W/8-1:0]      i_ld_be,
    output logic                     o_ld_hit,
    output logic [DATA_W-1:0]        o_ld_data,
    output logic                     o_ld_stall,
    output logic                     o_mem_we,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [DATA_W-1:0]        o_mem_data,
    output logic [DATA_W/8-1:0]      o_mem_be,
    input  logic                     i_mem_ack,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(BE_W - 1);
    endfunction

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [BE_W-1:0]   be_q   [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, tail_q, youngest;
    logic [CNT_W-1:0]  count_q;

    logic              merge_possible, do_merge, do_push, do_pop;
    logic [DATA_W-1:0] st_mask;

    assign o_count    = count_q;
    assign o_empty    = (count_q == '0);
    assign o_full     = (count_q == CNT_W'(DEPTH));
    assign o_mem_we   = !o_empty;
    assign o_mem_addr = addr_q[head_q];
    assign o_mem_data = data_q[head_q];
    assign o_mem_be   = be_q[head_q];

    assign youngest = tail_q - PTR_W'(1);

    // The draining head is never a merge target so its fields stay stable until ack.
    assign merge_possible = COALESCE && valid_q[youngest]
                            && (addr_q[youngest] == word_addr(i_st_addr))
                            && !((youngest == head_q) && o_mem_we);

    assign o_st_ready = !o_full || merge_possible;
    assign do_merge   = i_st_valid && merge_possible;
    assign do_push    = i_st_valid && !merge_possible && !o_full;
    assign do_pop     = i_mem_ack && o_mem_we;

    always_comb begin
        st_mask = '0;
        for (int b = 0; b < int'(BE_W); b++) begin
            st_mask[b*8 +: 8] = {8{i_st_be[b]}};
        end
    end

    // Push and pop never target the same slot: tail==head only when empty or full.
    always_comb begin
        valid_d = valid_q;
        if (do_pop) valid_d[head_q] = 1'b0;
        if (do_push) valid_d[tail_q] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + PTR_W'(1);
            if (do_pop) head_q <= head_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            addr_q[tail_q] <= word_addr(i_st_addr);
            data_q[tail_q] <= i_st_data;
            be_q[tail_q]   <= i_st_be;
        end else if (do_merge) begin
            data_q[youngest] <= (data_q[youngest] & ~st_mask) | (i_st_data & st_mask);
            be_q[youngest]   <= be_q[youngest] | i_st_be;
        end
    end

    logic [PTR_W-1:0]  idx;
    logic [DATA_W-1:0] fwd_data;
    logic [BE_W-1:0]   covered;
    logic              any_match, all_covered;

    // Walk oldest to youngest so younger entries overwrite older bytes.
    always_comb begin
        idx       = '0;
        fwd_data  = '0;
        covered   = '0;
        any_match = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx] == word_addr(i_ld_addr))
                && |(be_q[idx] & i_ld_be)) begin
                any_match = 1'b1;
                for (int b = 0; b < int'(BE_W); b++) begin
                    if (be_q[idx][b]) begin
                        fwd_data[b*8 +: 8] = data_q[idx][b*8 +: 8];
                        covered[b]         = 1'b1;
                    end
                end
            end
        end
    end

    assign all_covered = ((covered & i_ld_be) == i_ld_be);
    assign o_ld_hit    = i_ld_valid && any_match && all_covered;
    assign o_ld_stall  = i_ld_valid && any_match && !all_covered;
    assign o_ld_data   = fwd_data;

endmodule
